// File: rtl/apb_initiator_bridge_if.sv
// Core-side request/response channel plus APB4 initiator pins for apb_initiator_bridge.
// master = bridge side, slave = core + APB peripheral side.
interface apb_initiator_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              req_write;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_wstrb;
   logic [2:0]        req_prot;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] out_paddr;
   logic              out_psel;
   logic              out_penable;
   logic [2:0]        out_pprot;
   logic              out_pwrite;
   logic [DATA_W-1:0] out_pwdata;
   logic [STRB_W-1:0] out_pstrb;
   logic              out_pready;
   logic [DATA_W-1:0] out_prdata;
   logic              out_pslverr;

   modport master (
      input  req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot, resp_ready,
             out_pready, out_prdata, out_pslverr,
      output req_ready, resp_valid, resp_rdata, resp_err,
             out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
   );

   modport slave (
      output req_valid, req_addr, req_write, req_wdata, req_wstrb, req_prot, resp_ready,
             out_pready, out_prdata, out_pslverr,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
   );
endinterface

// File: rtl/apb_initiator_bridge.sv
// Single-outstanding valid/ready -> APB4 initiator: SETUP/ACCESS sequencing with a
// pready watchdog; response carries rdata and pslverr/timeout error.
module apb_initiator_bridge #(
   parameter int          ADDR_W  = 32,
   parameter int          DATA_W  = 32,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   apb_initiator_bridge_if.master io_bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

   state_t            r_state;
   logic              r_psel;
   logic              r_penable;
   logic              r_pwrite;
   logic [ADDR_W-1:0] r_paddr;
   logic [DATA_W-1:0] r_pwdata;
   logic [STRB_W-1:0] r_pstrb;
   logic [2:0]        r_pprot;
   logic              r_resp_valid;
   logic [DATA_W-1:0] r_resp_rdata;
   logic              r_resp_err;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_timeout;

   // r_cnt holds the number of wait cycles already seen, so the abort lands on ACCESS cycle TIMEOUT
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_pwrite     <= 1'b0;
         r_paddr      <= '0;
         r_pwdata     <= '0;
         r_pstrb      <= '0;
         r_pprot      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_bus.req_valid) begin
                  r_paddr  <= io_bus.req_addr;
                  r_pwrite <= io_bus.req_write;
                  r_pwdata <= io_bus.req_wdata;
                  r_pprot  <= io_bus.req_prot;
                  // APB4: reads drive no strobes
                  r_pstrb  <= io_bus.req_write ? io_bus.req_wstrb : '0;
                  r_psel   <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (io_bus.out_pready) begin
                  r_resp_rdata <= r_pwrite ? '0 : io_bus.out_prdata;
                  r_resp_err   <= io_bus.out_pslverr;
                  r_psel       <= 1'b0;
                  r_penable    <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else if (w_timeout) begin
                  r_resp_rdata <= '0;
                  r_resp_err   <= 1'b1;
                  r_psel       <= 1'b0;
                  r_penable    <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (io_bus.resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.req_ready   = (r_state == S_IDLE);
   assign io_bus.resp_valid  = r_resp_valid;
   assign io_bus.resp_rdata  = r_resp_rdata;
   assign io_bus.resp_err    = r_resp_err;
   assign io_bus.out_paddr   = r_paddr;
   assign io_bus.out_psel    = r_psel;
   assign io_bus.out_penable = r_penable;
   assign io_bus.out_pprot   = r_pprot;
   assign io_bus.out_pwrite  = r_pwrite;
   assign io_bus.out_pwdata  = r_pwdata;
   assign io_bus.out_pstrb   = r_pstrb;
endmodule

// File: tb/tb_apb_initiator_bridge.sv
// Bench for apb_initiator_bridge: DUT A (TIMEOUT=8) for directed/random transfers,
// DUT B (TIMEOUT=0) for the disabled-watchdog long wait.
module tb_apb_initiator_bridge;
   localparam int TO_A = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   apb_initiator_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
   apb_initiator_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

   apb_initiator_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO_A)) u_a (
      .i_clk(clk), .i_rst(rst), .io_bus(bus_a.master));
   apb_initiator_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_b (
      .i_clk(clk), .i_rst(rst), .io_bus(bus_b.master));

   // Reference outcome of one transfer: the slave holds pready low for 'waits' ACCESS cycles.
   function automatic void model(input int waits, input logic wr, input logic [31:0] prdata,
                                 input logic slverr, input int tmo, output int acc,
                                 output logic [31:0] rdata, output logic err);
      if (tmo != 0 && waits >= tmo) begin
         acc = tmo; rdata = 32'h0; err = 1'b1;
      end else begin
         acc = waits + 1; rdata = wr ? 32'h0 : prdata; err = slverr;
      end
   endfunction

   // Drives one transfer on DUT A, acting as core and APB slave, and reports what it observed.
   task automatic xfer_a(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] prot, input int waits,
                         input logic [31:0] prdata, input logic slverr, input int hold,
                         output int lat, output int acc, output logic [31:0] rdata,
                         output logic err, output int field_bad, output int resp_bad,
                         output logic hung);
      logic [3:0] exp_strb;
      exp_strb = wr ? wstrb : 4'h0;
      field_bad = 0; resp_bad = 0; hung = 1'b0; lat = 0; acc = 0; rdata = '0; err = 1'b0;
      @(negedge clk);
      if (bus_a.req_ready !== 1'b1) resp_bad++;
      bus_a.req_valid = 1'b1; bus_a.req_addr = addr; bus_a.req_write = wr;
      bus_a.req_wdata = wdata; bus_a.req_wstrb = wstrb; bus_a.req_prot = prot;
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0; bus_a.req_addr = $urandom; bus_a.req_wdata = $urandom;
      bus_a.req_write = 1'($urandom); bus_a.req_wstrb = 4'($urandom); bus_a.req_prot = 3'($urandom);
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         lat = c;
         if (bus_a.resp_valid === 1'b1) break;
         bus_a.resp_ready = 1'($urandom);
         if (bus_a.out_psel !== 1'b1) field_bad++;
         if (bus_a.out_paddr !== addr || bus_a.out_pwrite !== wr || bus_a.out_pwdata !== wdata ||
             bus_a.out_pstrb !== exp_strb || bus_a.out_pprot !== prot) field_bad++;
         if (bus_a.out_penable === 1'b1) begin
            acc++;
            bus_a.out_pready  = (acc > waits);
            bus_a.out_prdata  = (acc > waits) ? prdata : $urandom;
            bus_a.out_pslverr = (acc > waits) ? slverr : 1'($urandom);
         end else begin
            if (c != 1) field_bad++;
            bus_a.out_pready = 1'($urandom); bus_a.out_prdata = $urandom;
            bus_a.out_pslverr = 1'($urandom);
         end
      end
      if (bus_a.resp_valid !== 1'b1) hung = 1'b1;
      rdata = bus_a.resp_rdata; err = bus_a.resp_err;
      if (bus_a.out_psel !== 1'b0 || bus_a.out_penable !== 1'b0) resp_bad++;
      bus_a.out_pready = 1'($urandom); bus_a.out_prdata = $urandom;
      bus_a.out_pslverr = 1'($urandom);
      bus_a.resp_ready = 1'b0;
      bus_a.req_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (bus_a.resp_valid !== 1'b1 || bus_a.resp_rdata !== rdata || bus_a.resp_err !== err ||
             bus_a.req_ready !== 1'b0 || bus_a.out_psel !== 1'b0) resp_bad++;
      end
      bus_a.req_valid = 1'b0;
      bus_a.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus_a.resp_ready = 1'b0;
      @(negedge clk);
      if (bus_a.resp_valid !== 1'b0 || bus_a.req_ready !== 1'b1 || bus_a.out_psel !== 1'b0)
         resp_bad++;
   endtask

   task automatic test_reset();
      n_cmp++; if (bus_a.out_psel !== 1'b0 || bus_a.out_penable !== 1'b0) begin
         n_bad++; $display("FAIL reset_psel psel=%b penable=%b exp 0/0", bus_a.out_psel, bus_a.out_penable); end
      n_cmp++; if (bus_a.out_paddr !== 32'h0 || bus_a.out_pwdata !== 32'h0) begin
         n_bad++; $display("FAIL reset_addr_data paddr=%h pwdata=%h exp 0", bus_a.out_paddr, bus_a.out_pwdata); end
      n_cmp++; if (bus_a.out_pstrb !== 4'h0 || bus_a.out_pprot !== 3'h0 || bus_a.out_pwrite !== 1'b0) begin
         n_bad++; $display("FAIL reset_ctrl pstrb=%h pprot=%h pwrite=%b exp 0", bus_a.out_pstrb, bus_a.out_pprot, bus_a.out_pwrite); end
      n_cmp++; if (bus_a.resp_valid !== 1'b0 || bus_a.resp_rdata !== 32'h0 || bus_a.resp_err !== 1'b0) begin
         n_bad++; $display("FAIL reset_resp valid=%b rdata=%h err=%b exp 0", bus_a.resp_valid, bus_a.resp_rdata, bus_a.resp_err); end
      n_cmp++; if (bus_a.req_ready !== 1'b1 || bus_b.req_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_ready a=%b b=%b exp 1", bus_a.req_ready, bus_b.req_ready); end
   endtask

   task automatic test_read_zero_wait();
      int lat, acc, fb, rb; logic [31:0] rd; logic er, hung;
      xfer_a(32'h0000_0040, 1'b0, 32'h1111_2222, 4'h0, 3'h2, 0, 32'hDEAD_BEEF, 1'b0, 0,
             lat, acc, rd, er, fb, rb, hung);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL t1_latency got %0d exp 3", lat); end
      n_cmp++; if (acc !== 1) begin n_bad++; $display("FAIL t1_access got %0d exp 1", acc); end
      n_cmp++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
         n_bad++; $display("FAIL t1_resp rdata=%h err=%b exp deadbeef/0", rd, er); end
      n_cmp++; if (fb !== 0 || rb !== 0 || hung !== 1'b0) begin
         n_bad++; $display("FAIL t1_protocol field_bad=%0d resp_bad=%0d hung=%b exp 0", fb, rb, hung); end
   endtask

   task automatic test_write_waits();
      int lat, acc, fb, rb; logic [31:0] rd; logic er, hung;
      xfer_a(32'h1000_0004, 1'b1, 32'h1234_5678, 4'h3, 3'h1, 5, 32'hCAFE_F00D, 1'b0, 1,
             lat, acc, rd, er, fb, rb, hung);
      n_cmp++; if (acc !== 6) begin n_bad++; $display("FAIL t2_access got %0d exp 6", acc); end
      n_cmp++; if (fb !== 0) begin n_bad++; $display("FAIL t2_stable field_bad=%0d exp 0", fb); end
      n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin
         n_bad++; $display("FAIL t2_resp rdata=%h err=%b exp 0/0", rd, er); end
      n_cmp++; if (rb !== 0 || hung !== 1'b0) begin
         n_bad++; $display("FAIL t2_handshake resp_bad=%0d hung=%b exp 0", rb, hung); end
   endtask

   task automatic test_read_strobe_err();
      int lat, acc, fb, rb; logic [31:0] rd; logic er, hung;
      xfer_a(32'h2000_0010, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'h7, 2, 32'h0BAD_0BAD, 1'b1, 0,
             lat, acc, rd, er, fb, rb, hung);
      n_cmp++; if (fb !== 0) begin n_bad++; $display("FAIL t3_pstrb field_bad=%0d exp 0", fb); end
      n_cmp++; if (er !== 1'b1 || rd !== 32'h0BAD_0BAD) begin
         n_bad++; $display("FAIL t3_slverr err=%b rdata=%h exp 1/0bad0bad", er, rd); end
      n_cmp++; if (acc !== 3 || rb !== 0) begin
         n_bad++; $display("FAIL t3_access acc=%0d resp_bad=%0d exp 3/0", acc, rb); end
   endtask

   task automatic test_timeout();
      int lat, acc, fb, rb, bad; logic [31:0] rd; logic er, hung;
      xfer_a(32'h3000_0000, 1'b0, 32'h0, 4'h0, 3'h0, 1000, 32'h5555_AAAA, 1'b0, 0,
             lat, acc, rd, er, fb, rb, hung);
      n_cmp++; if (acc !== TO_A) begin n_bad++; $display("FAIL t4_abort_cycles got %0d exp %0d", acc, TO_A); end
      n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin
         n_bad++; $display("FAIL t4_abort_resp err=%b rdata=%h exp 1/0", er, rd); end
      n_cmp++; if (rb !== 0 || fb !== 0) begin
         n_bad++; $display("FAIL t4_abort_psel resp_bad=%0d field_bad=%0d exp 0", rb, fb); end
      // pready arriving on the last allowed cycle still completes normally
      xfer_a(32'h3000_0004, 1'b0, 32'h0, 4'h0, 3'h0, TO_A - 1, 32'h7777_8888, 1'b0, 0,
             lat, acc, rd, er, fb, rb, hung);
      n_cmp++; if (acc !== TO_A || er !== 1'b0 || rd !== 32'h7777_8888) begin
         n_bad++; $display("FAIL t4_edge acc=%0d err=%b rdata=%h exp %0d/0/77778888", acc, er, rd, TO_A); end
      // watchdog disabled: 10000 wait cycles must not abort
      bad = 0;
      @(negedge clk);
      bus_b.req_valid = 1'b1; bus_b.req_addr = 32'h4000_0000; bus_b.req_write = 1'b0;
      bus_b.out_pready = 1'b0;
      @(posedge clk); #1;
      bus_b.req_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         if (bus_b.out_psel !== 1'b1 || bus_b.out_penable !== 1'b1 || bus_b.resp_valid !== 1'b0) bad++;
      end
      bus_b.out_pready = 1'b1; bus_b.out_prdata = 32'hA5A5_5A5A; bus_b.out_pslverr = 1'b0;
      @(negedge clk);
      bus_b.out_pready = 1'b0;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t4_no_watchdog bad_cycles=%0d exp 0", bad); end
      n_cmp++; if (bus_b.resp_valid !== 1'b1 || bus_b.resp_err !== 1'b0 || bus_b.resp_rdata !== 32'hA5A5_5A5A) begin
         n_bad++; $display("FAIL t4_no_watchdog_resp valid=%b err=%b rdata=%h exp 1/0/a5a55a5a",
                           bus_b.resp_valid, bus_b.resp_err, bus_b.resp_rdata); end
      bus_b.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus_b.resp_ready = 1'b0;
   endtask

   task automatic test_resp_backpressure();
      int lat, acc, fb, rb; logic [31:0] rd; logic er, hung;
      xfer_a(32'h5000_0008, 1'b0, 32'h0, 4'h0, 3'h3, 1, 32'h1357_9BDF, 1'b0, 7,
             lat, acc, rd, er, fb, rb, hung);
      n_cmp++; if (rb !== 0) begin n_bad++; $display("FAIL t5_hold resp_bad=%0d exp 0", rb); end
      n_cmp++; if (rd !== 32'h1357_9BDF || er !== 1'b0) begin
         n_bad++; $display("FAIL t5_resp rdata=%h err=%b exp 13579bdf/0", rd, er); end
      xfer_a(32'h5000_000C, 1'b1, 32'h2468_ACE0, 4'hC, 3'h0, 0, 32'h0, 1'b0, 0,
             lat, acc, rd, er, fb, rb, hung);
      n_cmp++; if (lat !== 3 || fb !== 0 || rb !== 0) begin
         n_bad++; $display("FAIL t5_next lat=%0d field_bad=%0d resp_bad=%0d exp 3/0/0", lat, fb, rb); end
   endtask

   task automatic test_back_to_back();
      int lat, acc, fb, rb, waits, hold, e_acc; logic [31:0] rd, addr, wdata, prdata, e_rd;
      logic er, hung, wr, sl, e_er; logic [3:0] strb; logic [2:0] prot;
      for (int t = 0; t < 30; t++) begin
         addr = $urandom; wdata = $urandom; prdata = $urandom; wr = 1'($urandom);
         sl = 1'($urandom); strb = 4'($urandom); prot = 3'($urandom);
         waits = $urandom_range(0, 11); hold = $urandom_range(0, 3);
         model(waits, wr, prdata, sl, TO_A, e_acc, e_rd, e_er);
         xfer_a(addr, wr, wdata, strb, prot, waits, prdata, sl, hold,
                lat, acc, rd, er, fb, rb, hung);
         n_cmp++; if (acc !== e_acc || lat !== e_acc + 2) begin
            n_bad++; $display("FAIL rnd%0d_timing acc=%0d lat=%0d exp %0d/%0d", t, acc, lat, e_acc, e_acc + 2); end
         n_cmp++; if (rd !== e_rd || er !== e_er) begin
            n_bad++; $display("FAIL rnd%0d_resp rdata=%h err=%b exp %h/%b", t, rd, er, e_rd, e_er); end
         n_cmp++; if (fb !== 0 || rb !== 0 || hung !== 1'b0) begin
            n_bad++; $display("FAIL rnd%0d_protocol field_bad=%0d resp_bad=%0d hung=%b exp 0", t, fb, rb, hung); end
      end
   endtask

   task automatic test_reset_mid();
      int lat, acc, fb, rb; logic [31:0] rd; logic er, hung;
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_addr = 32'h6000_0000; bus_a.req_write = 1'b1;
      bus_a.req_wdata = 32'hFEED_FACE; bus_a.req_wstrb = 4'hF;
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0; bus_a.out_pready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (bus_a.out_psel !== 1'b1 || bus_a.out_penable !== 1'b1) begin
         n_bad++; $display("FAIL t6_in_access psel=%b penable=%b exp 1/1", bus_a.out_psel, bus_a.out_penable); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (bus_a.out_psel !== 1'b0 || bus_a.out_penable !== 1'b0 || bus_a.resp_valid !== 1'b0) begin
         n_bad++; $display("FAIL t6_async psel=%b penable=%b resp_valid=%b exp 0",
                           bus_a.out_psel, bus_a.out_penable, bus_a.resp_valid); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus_a.req_ready !== 1'b1 || bus_a.resp_valid !== 1'b0) begin
         n_bad++; $display("FAIL t6_after ready=%b resp_valid=%b exp 1/0", bus_a.req_ready, bus_a.resp_valid); end
      xfer_a(32'h6000_0010, 1'b0, 32'h0, 4'h0, 3'h0, 0, 32'h0F0F_F0F0, 1'b0, 0,
             lat, acc, rd, er, fb, rb, hung);
      n_cmp++; if (lat !== 3 || rd !== 32'h0F0F_F0F0 || er !== 1'b0 || fb !== 0 || rb !== 0) begin
         n_bad++; $display("FAIL t6_next_read lat=%0d rdata=%h err=%b fb=%0d rb=%0d exp 3/0f0ff0f0/0/0/0",
                           lat, rd, er, fb, rb); end
   endtask

   initial begin
      rst = 1'b1;
      bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_write = 1'b0; bus_a.req_wdata = '0;
      bus_a.req_wstrb = '0; bus_a.req_prot = '0; bus_a.resp_ready = 1'b0;
      bus_a.out_pready = 1'b0; bus_a.out_prdata = '0; bus_a.out_pslverr = 1'b0;
      bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_write = 1'b0; bus_b.req_wdata = '0;
      bus_b.req_wstrb = '0; bus_b.req_prot = '0; bus_b.resp_ready = 1'b0;
      bus_b.out_pready = 1'b0; bus_b.out_prdata = '0; bus_b.out_pslverr = 1'b0;
      #22;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_read_zero_wait();
      test_write_waits();
      test_read_strobe_err();
      test_timeout();
      test_resp_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
